// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave to single-cycle core register/memory bus bridge.
// Write and read channels run independent FSMs; every output is a flop.
// Out-of-map addresses (>= ADDR_LIMIT) get SLVERR and never touch the core.
module axi_lite_slave_bridge #(
    parameter int ADDR_WIDTH = 20,
    parameter int ADDR_LIMIT = 549228,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  core_wr_en,
    output logic [ADDR_WIDTH-1:0] core_wr_addr,
    output logic [31:0]           core_wr_data,
    output logic [3:0]            core_wr_strobe,
    output logic                  core_rd_en,
    output logic [ADDR_WIDTH-1:0] core_rd_addr,
    input  logic [31:0]           core_rd_data
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] LIMIT       = ADDR_LIMIT;
    localparam logic [1:0]  LAT         = 2'(RD_LATENCY);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;

    // ---------------- write channel state ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [3:0]            wr_strb_q, wr_strb_d;
    logic                  aw_in_range;

    // ---------------- read channel state ----------------
    r_state_e              r_state_q, r_state_d;
    logic                  ar_held_q, ar_held_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  ar_in_range;

    assign aw_in_range = (32'(aw_addr_q) < LIMIT);
    assign ar_in_range = (32'(ar_addr_q) < LIMIT);

    // Write FSM next state: collect AW and W in any order, strobe once, respond.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    w_state_d = W_EXEC;
                    if (aw_in_range) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = aw_addr_q;
                        wr_data_d = w_data_q;
                        wr_strb_d = w_strb_q;
                        bresp_d   = RESP_OKAY;
                    end else begin
                        bresp_d   = RESP_SLVERR;
                    end
                end else begin
                    if (s_awvalid && awready_q) begin
                        aw_held_d = 1'b1;
                        aw_addr_d = s_awaddr;
                    end
                    if (s_wvalid && wready_q) begin
                        w_held_d = 1'b1;
                        w_data_d = s_wdata;
                        w_strb_d = s_wstrb;
                    end
                end
            end
            W_EXEC: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // Readies are registered, so they reflect the state being entered.
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Write channel registers; reset discards any held beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
        end
    end

    // Read FSM next state: accept AR, issue one core read, wait out the latency, respond.
    always_comb begin
        r_state_d = r_state_q;
        ar_held_d = ar_held_q;
        ar_addr_d = ar_addr_q;
        lat_cnt_d = lat_cnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_held_q) begin
                    if (ar_in_range) begin
                        r_state_d = R_ISSUE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ar_addr_q;
                    end else begin
                        r_state_d = R_RESP;
                        rvalid_d  = 1'b1;
                        rdata_d   = '0;
                        rresp_d   = RESP_SLVERR;
                    end
                end else if (s_arvalid && arready_q) begin
                    ar_held_d = 1'b1;
                    ar_addr_d = s_araddr;
                end
            end
            R_ISSUE: begin
                if (LAT == 2'd0) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = core_rd_data;
                    rresp_d   = RESP_OKAY;
                end else begin
                    r_state_d = R_WAIT;
                    lat_cnt_d = LAT;
                end
            end
            R_WAIT: begin
                // Last wait cycle: core data is valid now, capture it.
                if (lat_cnt_q == 2'd1) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = core_rd_data;
                    rresp_d   = RESP_OKAY;
                end
                lat_cnt_d = lat_cnt_q - 2'd1;
            end
            R_RESP: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    ar_held_d = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE) && !ar_held_d;
    end

    // Read channel registers; core_rd_addr only changes when a new read issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            ar_held_q <= 1'b0;
            ar_addr_q <= '0;
            lat_cnt_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            ar_held_q <= ar_held_d;
            ar_addr_q <= ar_addr_d;
            lat_cnt_q <= lat_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign s_awready      = awready_q;
    assign s_wready       = wready_q;
    assign s_bvalid       = bvalid_q;
    assign s_bresp        = bresp_q;
    assign s_arready      = arready_q;
    assign s_rvalid       = rvalid_q;
    assign s_rresp        = rresp_q;
    assign s_rdata        = rdata_q;
    assign core_wr_en     = wr_en_q;
    assign core_wr_addr   = wr_addr_q;
    assign core_wr_data   = wr_data_q;
    assign core_wr_strobe = wr_strb_q;
    assign core_rd_en     = rd_en_q;
    assign core_rd_addr   = rd_addr_q;

endmodule
